// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order FIFO of committed stores drained to the data-memory write port.
// Optional `STORE_FWD_EN adds full-word store-to-load forwarding outputs (fwdValid/fwdData).
module store_commit_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memoryWriteEnable,
  input  logic [31:0] memoryWriteAddr,
  input  logic [31:0] memoryWriteData,
  input  logic [2:0]  memoryWriteType,
  output logic        bufFull,
  output logic        bufEmpty,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memByteEn,
  input  logic        memAck,
  input  logic [31:0] loadCheckAddr,
  output logic        loadConflict,
  output logic        overflowErr,
  output logic        misalignErr
`ifdef STORE_FWD_EN
  ,
  output logic        fwdValid,
  output logic [31:0] fwdData
`endif
);

  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [29:0] entWord_q [DEPTH];
  logic [31:0] entData_q [DEPTH];
  logic [3:0]  entBe_q   [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic        memReq_q, memReq_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWData_q, memWData_d;
  logic [3:0]  memByteEn_q, memByteEn_d;
  logic        overflowErr_q, misalignErr_q;

  logic        full;
  logic        pushOk;
  logic        pop;
  logic        fmtLegal;
  logic [3:0]  fmtBe;
  logic [31:0] fmtData;

  logic             conflictAny;
  logic             youngestFull;
  logic [31:0]      youngestData;
  logic [PTR_W-1:0] scanIdx;
  logic             unusedLoadLsbs;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign bufFull  = full;
  assign bufEmpty = (count_q == '0);

  // Lane replication and byte-enable generation; illegal or misaligned stores never enter the queue.
  always_comb begin
    fmtLegal = 1'b0;
    fmtBe    = 4'b0000;
    fmtData  = 32'h0;
    case (memoryWriteType)
      3'b000: begin
        fmtLegal = 1'b1;
        fmtBe    = 4'b0001 << memoryWriteAddr[1:0];
        fmtData  = {4{memoryWriteData[7:0]}};
      end
      3'b001: begin
        fmtLegal = ~memoryWriteAddr[0];
        fmtBe    = memoryWriteAddr[1] ? 4'b1100 : 4'b0011;
        fmtData  = {2{memoryWriteData[15:0]}};
      end
      3'b010: begin
        fmtLegal = (memoryWriteAddr[1:0] == 2'b00);
        fmtBe    = 4'b1111;
        fmtData  = memoryWriteData;
      end
      default: ;
    endcase
  end

  // Full is judged on the pre-edge count, so a same-cycle pop never makes room for this push.
  assign pushOk  = memoryWriteEnable && !full && fmtLegal;
  assign count_d = count_q + CNT_W'(pushOk) - CNT_W'(pop);

  always_comb begin
    state_d     = state_q;
    memReq_d    = memReq_q;
    memAddr_d   = memAddr_q;
    memWData_d  = memWData_q;
    memByteEn_d = memByteEn_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          memReq_d    = 1'b1;
          memAddr_d   = {entWord_q[head_q], 2'b00};
          memWData_d  = entData_q[head_q];
          memByteEn_d = entBe_q[head_q];
          state_d     = REQ;
        end
      end
      REQ: begin
        if (memAck) begin
          pop      = 1'b1;
          memReq_d = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      memReq_q      <= 1'b0;
      memAddr_q     <= 32'h0;
      memWData_q    <= 32'h0;
      memByteEn_q   <= 4'b0000;
      overflowErr_q <= 1'b0;
      misalignErr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      memReq_q      <= memReq_d;
      memAddr_q     <= memAddr_d;
      memWData_q    <= memWData_d;
      memByteEn_q   <= memByteEn_d;
      overflowErr_q <= overflowErr_q | (memoryWriteEnable & full);
      misalignErr_q <= misalignErr_q | (memoryWriteEnable & ~fmtLegal);
      if (pushOk) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
    end
  end

  // Entry payload needs no reset: validity is implied by head and count.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      entWord_q[tail_q] <= memoryWriteAddr[31:2];
      entData_q[tail_q] <= fmtData;
      entBe_q[tail_q]   <= fmtBe;
    end
  end

  assign memReq      = memReq_q;
  assign memAddr     = memAddr_q;
  assign memWData    = memWData_q;
  assign memByteEn   = memByteEn_q;
  assign overflowErr = overflowErr_q;
  assign misalignErr = misalignErr_q;

  // Scan oldest to youngest so the last hit left standing is the entry nearest the tail.
  always_comb begin
    conflictAny  = 1'b0;
    youngestFull = 1'b0;
    youngestData = 32'h0;
    scanIdx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (entWord_q[scanIdx] == loadCheckAddr[31:2])) begin
        conflictAny  = 1'b1;
        youngestFull = (entBe_q[scanIdx] == 4'b1111);
        youngestData = entData_q[scanIdx];
      end
    end
  end

  assign unusedLoadLsbs = ^loadCheckAddr[1:0];

`ifdef STORE_FWD_EN
  assign fwdValid     = conflictAny & youngestFull;
  assign fwdData      = fwdValid ? youngestData : 32'h0;
  assign loadConflict = conflictAny & ~youngestFull;
`else
  assign loadConflict = conflictAny;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model of the store buffer.
module tb_store_commit_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        memoryWriteEnable;
  logic [31:0] memoryWriteAddr;
  logic [31:0] memoryWriteData;
  logic [2:0]  memoryWriteType;
  logic        bufFull;
  logic        bufEmpty;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] loadCheckAddr;
  logic        loadConflict;
  logic        overflowErr;
  logic        misalignErr;
`ifdef STORE_FWD_EN
  logic        fwdValid;
  logic [31:0] fwdData;
`endif

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } store_t;

  store_t model[$];
  logic   expOverflow;
  logic   expMisalign;
  int     assertCount;
  int     failCount;
  int     writesSeen;

  store_commit_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .memoryWriteEnable(memoryWriteEnable),
    .memoryWriteAddr  (memoryWriteAddr),
    .memoryWriteData  (memoryWriteData),
    .memoryWriteType  (memoryWriteType),
    .bufFull          (bufFull),
    .bufEmpty         (bufEmpty),
    .memReq           (memReq),
    .memAddr          (memAddr),
    .memWData         (memWData),
    .memByteEn        (memByteEn),
    .memAck           (memAck),
    .loadCheckAddr    (loadCheckAddr),
    .loadConflict     (loadConflict),
    .overflowErr      (overflowErr),
    .misalignErr      (misalignErr)
`ifdef STORE_FWD_EN
    ,
    .fwdValid         (fwdValid),
    .fwdData          (fwdData)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference formatting straight from the store-type rules, using arithmetic replication.
  function automatic logic fmtStore(input logic [31:0] a, input logic [31:0] d,
                                    input logic [2:0] t, output store_t s);
    int off;
    off    = int'(a % 4);
    s.word = a[31:2];
    s.data = 32'h0;
    s.be   = 4'h0;
    if (t == 3'd0) begin
      s.be   = 4'(1 << off);
      s.data = (d & 32'hFF) * 32'h01010101;
      return 1'b1;
    end
    if (t == 3'd1 && (off % 2) == 0) begin
      s.be   = (off == 2) ? 4'hC : 4'h3;
      s.data = (d & 32'hFFFF) * 32'h00010001;
      return 1'b1;
    end
    if (t == 3'd2 && off == 0) begin
      s.be   = 4'hF;
      s.data = d;
      return 1'b1;
    end
    return 1'b0;
  endfunction

`ifdef STORE_FWD_EN
  function automatic void expFwd(output logic v, output logic [31:0] d);
    v = 1'b0;
    d = 32'h0;
    for (int i = model.size() - 1; i >= 0; i--) begin
      if (model[i].word == loadCheckAddr[31:2]) begin
        v = (model[i].be == 4'hF);
        d = v ? model[i].data : 32'h0;
        break;
      end
    end
  endfunction
`endif

  function automatic logic expConflict();
    logic hit;
`ifdef STORE_FWD_EN
    logic        fv;
    logic [31:0] fd;
`endif
    hit = 1'b0;
    foreach (model[i]) begin
      if (model[i].word == loadCheckAddr[31:2]) hit = 1'b1;
    end
`ifdef STORE_FWD_EN
    expFwd(fv, fd);
    if (fv) hit = 1'b0;
`endif
    return hit;
  endfunction

  // Advances one clock: updates the model from pre-edge inputs and scoreboards completed writes.
  task automatic step();
    logic   wasFull;
    logic   legal;
    store_t s;
    wasFull = (model.size() == DEPTH);
    if (memReq && memAck) begin
      writesSeen++;
      assertCount++;
      if (model.size() == 0) begin
        failCount++;
        $display("[TB] FAIL write_order: write addr=%h with empty model", memAddr);
      end else begin
        if ({memAddr, memWData, memByteEn} !== {model[0].word, 2'b00, model[0].data, model[0].be}) begin
          failCount++;
          $display("[TB] FAIL write_order: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                   memAddr, memWData, memByteEn, {model[0].word, 2'b00}, model[0].data, model[0].be);
        end
        void'(model.pop_front());
      end
    end
    if (memoryWriteEnable) begin
      legal = fmtStore(memoryWriteAddr, memoryWriteData, memoryWriteType, s);
      if (wasFull) expOverflow = 1'b1;
      else if (legal) model.push_back(s);
      if (!legal) expMisalign = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drivePush(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    memoryWriteEnable = 1'b1;
    memoryWriteAddr   = a;
    memoryWriteData   = d;
    memoryWriteType   = t;
    step();
    memoryWriteEnable = 1'b0;
  endtask

  task automatic drainAll(input string tag);
    int budget;
    budget = 60;
    memAck = 1'b1;
    while ((model.size() != 0 || memReq) && budget > 0) begin
      step();
      budget--;
    end
    memAck = 1'b0;
    assertCount++;
    if (budget == 0) begin
      failCount++;
      $display("[TB] FAIL %s_drain_timeout: %0d entries left, required 0", tag, model.size());
    end
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    memoryWriteEnable = 1'b0;
    memoryWriteAddr   = 32'h0;
    memoryWriteData   = 32'h0;
    memoryWriteType   = 3'd0;
    memAck            = 1'b0;
    loadCheckAddr     = 32'h0;
    model.delete();
    expOverflow = 1'b0;
    expMisalign = 1'b0;
    #12;
    assertCount++;
    if ({memReq, memAddr, memWData, memByteEn} !== {1'b0, 32'h0, 32'h0, 4'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_mem_port: got req=%b addr=%h data=%h be=%b, expected all zero",
               memReq, memAddr, memWData, memByteEn);
    end
    assertCount++;
    if ({bufEmpty, bufFull, overflowErr, misalignErr} !== 4'b1000) begin
      failCount++;
      $display("[TB] FAIL reset_status: got empty/full/ovf/mis=%b, expected 1000",
               {bufEmpty, bufFull, overflowErr, misalignErr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    drivePush(32'h100, 32'hDEADBEEF, 3'd2);
    assertCount++;
    if (memReq !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL sw_req_latency: memReq=%b one edge after push, expected 0", memReq);
    end
    step();
    assertCount++;
    if ({memReq, memAddr, memByteEn, memWData} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
      failCount++;
      $display("[TB] FAIL sw_request: got req=%b addr=%h be=%b data=%h, expected 1 00000100 1111 deadbeef",
               memReq, memAddr, memByteEn, memWData);
    end
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    assertCount++;
    if ({memReq, bufEmpty} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL sw_complete: got req=%b empty=%b, expected req=0 empty=1", memReq, bufEmpty);
    end
  endtask

  task automatic test_sub_word();
    drivePush(32'h203, 32'h000000AB, 3'd0);
    drivePush(32'h206, 32'h00001234, 3'd1);
    step();
    assertCount++;
    if ({memAddr, memByteEn, memWData} !== {32'h200, 4'b1000, 32'hABABABAB}) begin
      failCount++;
      $display("[TB] FAIL sb_format: got addr=%h be=%b data=%h, expected 00000200 1000 abababab",
               memAddr, memByteEn, memWData);
    end
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    step();
    assertCount++;
    if ({memReq, memAddr, memByteEn, memWData} !== {1'b1, 32'h204, 4'b1100, 32'h12341234}) begin
      failCount++;
      $display("[TB] FAIL sh_format: got req=%b addr=%h be=%b data=%h, expected 1 00000204 1100 12341234",
               memReq, memAddr, memByteEn, memWData);
    end
    drainAll("sub_word");
  endtask

  task automatic test_misalign();
    assertCount++;
    if (misalignErr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL misalign_pre: misalignErr=%b, expected 0", misalignErr);
    end
    drivePush(32'h102, 32'h11111111, 3'd2);
    drivePush(32'h100, 32'h22222222, 3'b011);
    step();
    step();
    assertCount++;
    if ({memReq, bufEmpty, misalignErr} !== 3'b011) begin
      failCount++;
      $display("[TB] FAIL misalign_drop: got req=%b empty=%b mis=%b, expected 0 1 1",
               memReq, bufEmpty, misalignErr);
    end
  endtask

  task automatic test_overflow();
    int startWrites;
    memAck = 1'b0;
    for (int i = 0; i < 4; i++) drivePush(32'h500 + 32'(4 * i), $urandom, 3'd2);
    assertCount++;
    if ({bufFull, overflowErr} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL full_after_four: got full=%b ovf=%b, expected 1 0", bufFull, overflowErr);
    end
    drivePush(32'h540, 32'hBAD0BAD0, 3'd2);
    assertCount++;
    if ({bufFull, overflowErr} !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL overflow_flag: got full=%b ovf=%b, expected 1 1", bufFull, overflowErr);
    end
    startWrites = writesSeen;
    drainAll("overflow");
    assertCount++;
    if (writesSeen - startWrites != 4) begin
      failCount++;
      $display("[TB] FAIL overflow_write_count: got %0d writes, expected 4", writesSeen - startWrites);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] swData;
    swData = $urandom;
    memAck = 1'b0;
    drivePush(32'h300, swData, 3'd2);
    loadCheckAddr = 32'h302;
    #1;
    assertCount++;
    if (loadConflict !== expConflict()) begin
      failCount++;
      $display("[TB] FAIL conflict_same_word: got %b, expected %b", loadConflict, expConflict());
    end
    loadCheckAddr = 32'h304;
    #1;
    assertCount++;
    if (loadConflict !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL conflict_other_word: got %b, expected 0", loadConflict);
    end
`ifdef STORE_FWD_EN
    loadCheckAddr = 32'h300;
    #1;
    assertCount++;
    if ({fwdValid, fwdData, loadConflict} !== {1'b1, swData, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL fwd_full_word: got v=%b data=%h conf=%b, expected 1 %h 0",
               fwdValid, fwdData, loadConflict, swData);
    end
`endif
    @(negedge clk);
    drivePush(32'h301, 32'h000000C3, 3'd0);
    loadCheckAddr = 32'h300;
    #1;
    assertCount++;
    if (loadConflict !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL conflict_partial_young: got %b, expected 1", loadConflict);
    end
    @(negedge clk);
    drainAll("conflict");
    assertCount++;
    if (loadConflict !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL conflict_released: got %b, expected 0", loadConflict);
    end
  endtask

  task automatic test_random();
    logic [2:0] status;
`ifdef STORE_FWD_EN
    logic        ev;
    logic [31:0] ed;
`endif
    for (int c = 0; c < 400; c++) begin
      memoryWriteEnable = ($urandom % 3) == 0;
      memoryWriteAddr   = 32'h800 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      memoryWriteData   = $urandom;
      memoryWriteType   = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'b101;
      memAck            = $urandom_range(0, 1) == 1;
      loadCheckAddr     = 32'h800 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
      step();
      status = {model.size() == DEPTH, model.size() == 0, expConflict()};
      assertCount++;
      if ({bufFull, bufEmpty, loadConflict} !== status) begin
        failCount++;
        $display("[TB] FAIL rand_status cyc %0d: got full/empty/conf=%b, expected %b",
                 c, {bufFull, bufEmpty, loadConflict}, status);
      end
      assertCount++;
      if ({overflowErr, misalignErr} !== {expOverflow, expMisalign}) begin
        failCount++;
        $display("[TB] FAIL rand_errors cyc %0d: got ovf/mis=%b%b, expected %b%b",
                 c, overflowErr, misalignErr, expOverflow, expMisalign);
      end
      if (memReq) begin
        assertCount++;
        if (model.size() == 0 ||
            {memAddr, memWData, memByteEn} !== {model[0].word, 2'b00, model[0].data, model[0].be}) begin
          failCount++;
          $display("[TB] FAIL rand_head cyc %0d: got addr=%h data=%h be=%b, model holds %0d entries",
                   c, memAddr, memWData, memByteEn, model.size());
        end
      end
`ifdef STORE_FWD_EN
      expFwd(ev, ed);
      assertCount++;
      if ({fwdValid, fwdData} !== {ev, ed}) begin
        failCount++;
        $display("[TB] FAIL rand_fwd cyc %0d: got v=%b data=%h, expected v=%b data=%h",
                 c, fwdValid, fwdData, ev, ed);
      end
`endif
    end
    memoryWriteEnable = 1'b0;
    drainAll("random");
  endtask

  task automatic test_reset_mid_request();
    memAck = 1'b0;
    for (int i = 0; i < 3; i++) drivePush(32'h900 + 32'(4 * i), $urandom, 3'd2);
    assertCount++;
    if (memReq !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL mid_reset_setup: memReq=%b, expected 1", memReq);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model.delete();
    expOverflow = 1'b0;
    expMisalign = 1'b0;
    assertCount++;
    if ({memReq, bufEmpty, overflowErr, misalignErr} !== 4'b0100) begin
      failCount++;
      $display("[TB] FAIL mid_reset_async: got req/empty/ovf/mis=%b, expected 0100",
               {memReq, bufEmpty, overflowErr, misalignErr});
    end
    memAck = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      assertCount++;
      if ({memReq, bufEmpty} !== 2'b01) begin
        failCount++;
        $display("[TB] FAIL stale_ack cyc %0d: got req=%b empty=%b, expected 0 1", i, memReq, bufEmpty);
      end
    end
    memAck = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    writesSeen  = 0;
    test_reset();
    test_word_store();
    test_sub_word();
    test_misalign();
    test_overflow();
    test_conflict();
    test_random();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
